// File: rtl/logic_arb_pkg.sv
// Shared types and constants for the round-robin bitwise logic arbiter.
// Build option: LOGIC_ARB_STATS_EN enables per-requester grant counters.
package logic_arb_pkg;

    typedef enum logic [1:0] {
        OP_AND  = 2'b00,
        OP_OR   = 2'b01,
        OP_XOR  = 2'b10,
        OP_NAND = 2'b11
    } op_t;

    localparam int STAT_W = 16;

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/logic_op_unit.sv
// Shared combinational bitwise datapath: AND/OR/XOR/NAND at WIDTH bits.
module logic_op_unit
    import logic_arb_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  op_t              op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = '0;
        unique case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit_arbiter.sv
// Round-robin arbiter sharing one logic_op_unit with a one-entry response register.
// Build option: LOGIC_ARB_STATS_EN builds saturating per-requester grant counters.
module logic_unit_arbiter
    import logic_arb_pkg::*;
#(
    parameter  int N_REQ = 4,
    parameter  int WIDTH = 16,
    localparam int IDW   = id_w(N_REQ)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [N_REQ-1:0]                 req_valid,
    output logic [N_REQ-1:0]                 req_ready,
    input  logic [N_REQ-1:0][1:0]            req_op,
    input  logic [N_REQ-1:0][WIDTH-1:0]      req_a,
    input  logic [N_REQ-1:0][WIDTH-1:0]      req_b,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [IDW-1:0]                   rsp_id,
    output logic [WIDTH-1:0]                 rsp_data,
    output logic [N_REQ-1:0][STAT_W-1:0]     grant_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDW-1:0]   last_q;
    logic [IDW-1:0]   gidx;
    logic             found;
    logic             can_accept;
    logic             accept;
    int               idx;
    op_t              op_sel;
    logic [WIDTH-1:0] a_sel;
    logic [WIDTH-1:0] b_sel;
    logic [WIDTH-1:0] y;

    assign can_accept = (state_q == EMPTY) || rsp_ready;
    assign accept     = found && can_accept;
    assign rsp_valid  = (state_q == FULL);

    // Search starts just past the last grant and wraps, so each requester
    // waits at most N_REQ-1 accepts.
    always_comb begin
        found     = 1'b0;
        gidx      = '0;
        idx       = 0;
        req_ready = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            idx = (int'(last_q) + k) % N_REQ;
            if (!found && req_valid[IDW'(idx)]) begin
                found = 1'b1;
                gidx  = IDW'(idx);
            end
        end
        req_ready[gidx] = accept;
    end

    assign op_sel = op_t'(req_op[gidx]);
    assign a_sel  = req_a[gidx];
    assign b_sel  = req_b[gidx];

    logic_op_unit #(
        .WIDTH (WIDTH)
    ) u_op (
        .op (op_sel),
        .a  (a_sel),
        .b  (b_sel),
        .y  (y)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY:   if (accept) state_d = FULL;
            FULL:    if (rsp_ready && !accept) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= EMPTY;
            rsp_data <= '0;
            rsp_id   <= '0;
            last_q   <= IDW'(N_REQ - 1);
        end else begin
            state_q <= state_d;
            if (accept) begin
                rsp_data <= y;
                rsp_id   <= gidx;
                last_q   <= gidx;
            end
        end
    end

`ifdef LOGIC_ARB_STATS_EN
    logic [N_REQ-1:0][STAT_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && (cnt_q[i] != '1))
                    cnt_q[i] <= cnt_q[i] + 1'b1;
            end
        end
    end

    assign grant_count = cnt_q;
`else
    assign grant_count = '0;
`endif

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Randomized + directed bench for logic_unit_arbiter against a behavioural model.
module tb_logic_unit_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    logic                  clk;
    logic                  reset;
    logic [N-1:0]          req_valid;
    logic [N-1:0]          req_ready;
    logic [N-1:0][1:0]     req_op;
    logic [N-1:0][W-1:0]   req_a;
    logic [N-1:0][W-1:0]   req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [1:0]            rsp_id;
    logic [W-1:0]          rsp_data;
    logic [N-1:0][15:0]    grant_count;

    logic_unit_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_a       (req_a),
        .req_b       (req_b),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_data    (rsp_data),
        .grant_count (grant_count)
    );

    always #5 clk = ~clk;

`ifdef LOGIC_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int total;
    int passed;

    // behavioural model state
    bit          m_valid;
    logic [W-1:0] m_data;
    int          m_id;
    int          m_last;
    int          m_acc;
    int          m_cnt [N];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [W-1:0] opf(input logic [1:0] op,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b);
        case (op)
            2'd0:    return a & b;
            2'd1:    return a | b;
            2'd2:    return a ^ b;
            default: return ~(a & b);
        endcase
    endfunction

    function automatic int pick(input logic [N-1:0] v, input int last);
        for (int k = 1; k <= N; k++) begin
            int j = (last + k) % N;
            if (v[j]) return j;
        end
        return -1;
    endfunction

    function automatic logic [63:0] exp_counts();
        logic [63:0] e = '0;
        for (int i = 0; i < N; i++)
            if (STATS) e[i*16 +: 16] = 16'(m_cnt[i]);
        return e;
    endfunction

    task automatic model_clear();
        m_valid = 0;
        m_data  = '0;
        m_id    = 0;
        m_last  = N - 1;
        m_acc   = -1;
        for (int i = 0; i < N; i++) m_cnt[i] = 0;
    endtask

    // One clock: check every output against the model, then advance it.
    task automatic cycle();
        int g;
        bit can;
        logic [N-1:0] er;
        #1;
        g  = pick(req_valid, m_last);
        can = !m_valid || rsp_ready;
        er = '0;
        if (can && g >= 0) er[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(er));
        check("rsp_valid", 64'(rsp_valid), 64'(m_valid));
        check("rsp_id", 64'(rsp_id), 64'(m_id));
        check("rsp_data", 64'(rsp_data), 64'(m_data));
        check("grant_count", 64'(grant_count), exp_counts());
        @(posedge clk);
        m_acc = -1;
        if (can && g >= 0) begin
            m_data  = opf(req_op[g], req_a[g], req_b[g]);
            m_id    = g;
            m_last  = g;
            m_valid = 1;
            m_acc   = g;
            if (m_cnt[g] != 16'hFFFF) m_cnt[g]++;
        end else if (m_valid && rsp_ready) begin
            m_valid = 0;
        end
        @(negedge clk);
    endtask

    task automatic do_reset(input bit chk);
        reset = 1'b1;
        #1;
        if (chk) begin
            check("rst_valid", 64'(rsp_valid), 64'd0);
            check("rst_data", 64'(rsp_data), 64'd0);
            check("rst_id", 64'(rsp_id), 64'd0);
            check("rst_count", 64'(grant_count), 64'd0);
        end
        model_clear();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ops_exp [4];
        total = 0;
        passed = 0;
        clk = 0;
        reset = 1;
        req_valid = '0;
        req_op = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 0;
        model_clear();
        @(negedge clk);
        #1;
        check("init_valid", 64'(rsp_valid), 64'd0);
        check("init_data", 64'(rsp_data), 64'd0);
        @(negedge clk);
        reset = 0;

        // single request from requester 2
        req_valid = 4'b0100;
        req_op[2] = 2'b10;
        req_a[2] = 16'hF0F0;
        req_b[2] = 16'h0FF0;
        rsp_ready = 1;
        #1 check("single_ready", 64'(req_ready), 64'b0100);
        cycle();
        req_valid = '0;
        check("single_valid", 64'(rsp_valid), 64'd1);
        check("single_id", 64'(rsp_id), 64'd2);
        check("single_data", 64'(rsp_data), 64'hFF00);
        cycle();

        // round-robin with all four valid
        do_reset(0);
        for (int i = 0; i < N; i++) begin
            req_op[i] = 2'(i);
            req_a[i] = 16'h1234 + 16'(i);
            req_b[i] = 16'h0F0F;
        end
        req_valid = 4'hF;
        rsp_ready = 1;
        for (int i = 0; i < 6; i++) begin
            #1 check("rr_order", 64'(req_ready), 64'(1 << (i % 4)));
            cycle();
        end

        // backpressure with requester 1 waiting
        req_valid = 4'b0010;
        rsp_ready = 0;
        for (int i = 0; i < 5; i++) begin
            #1 check("bp_ready", 64'(req_ready), 64'd0);
            check("bp_id", 64'(rsp_id), 64'd1);
            cycle();
        end
        rsp_ready = 1;
        #1 check("bp_release", 64'(req_ready), 64'b0010);
        cycle();

        // all four ops on requester 0
        ops_exp[0] = 16'h00FF;
        ops_exp[1] = 16'hFFFF;
        ops_exp[2] = 16'hFF00;
        ops_exp[3] = 16'hFF00;
        req_valid = 4'b0001;
        req_a[0] = 16'hFFFF;
        req_b[0] = 16'h00FF;
        for (int i = 0; i < 4; i++) begin
            req_op[0] = 2'(i);
            cycle();
            check("op_data", 64'(rsp_data), 64'(ops_exp[i]));
        end

        // stats: requester 3 accepted seven times
        do_reset(0);
        req_valid = 4'b1000;
        rsp_ready = 1;
        for (int i = 0; i < 7; i++) cycle();
        req_valid = '0;
        rsp_ready = 0;
        #1 check("stats_count", 64'(grant_count),
                 STATS ? 64'h0007_0000_0000_0000 : 64'd0);
        cycle();

        // mid-run asynchronous reset with a held result
        check("pre_rst_valid", 64'(rsp_valid), 64'd1);
        do_reset(1);

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!(req_valid[i] && m_acc != i && $urandom_range(7) != 0)) begin
                    req_valid[i] = 1'($urandom_range(1));
                    req_op[i] = 2'($urandom_range(3));
                    req_a[i] = 16'($urandom);
                    req_b[i] = 16'($urandom);
                end
            end
            rsp_ready = ($urandom_range(3) != 0);
            if ($urandom_range(599) == 0) do_reset(1);
            else cycle();
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/logic_unit_arbiter.md
# logic_unit_arbiter

Shares one WIDTH-bit bitwise logic unit (AND/OR/XOR/NAND) between N_REQ requesters. Arbitration is round-robin, and the block uses valid/ready handshakes on both sides. Each accepted request is computed and held in a one-entry output register, tagged with the requester index, until the consumer takes it. It sits between the client ports and the shared logic datapath, and is the only block that drives that datapath.

## Interface
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand/result width
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high
- req_valid  input  N_REQ  request pending, one bit per requester
- req_ready  output  N_REQ  one-hot grant/accept; at most one bit high
- req_op  input  N_REQ x 2  operation per requester: 00 AND, 01 OR, 10 XOR, 11 NAND
- req_a, req_b  input  N_REQ x WIDTH  operands per requester
- rsp_valid  output  1  result register holds a result
- rsp_ready  input  1  consumer accepts result
- rsp_id  output  $clog2(N_REQ)  index of requester that produced rsp_data
- rsp_data  output  WIDTH  result
- grant_count  output  N_REQ x 16  per-requester accepted-request counters (see Configuration)

## Operation
- Two states: EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
- can_accept = EMPTY, or FULL with rsp_ready=1 (pass-through in the same cycle).
- Arbitration: if can_accept, req_ready asserts for the first requester with req_valid set.
  - Search order starts at last_grant+1 and wraps at N_REQ-1 to 0.
  - If no requester is valid, or can_accept=0, req_ready is all zero.
- Accept happens when req_valid[i] and req_ready[i] are both high at a clock edge. On accept:
  - rsp_data <= op(req_a[i], req_b[i]); rsp_id <= i; rsp_valid <= 1; last_grant <= i.
- Response taken (rsp_valid and rsp_ready high) with no accept in the same cycle: rsp_valid <= 0; rsp_data and rsp_id keep their values.
- Response taken and new accept in the same cycle: the register reloads and rsp_valid stays 1.
- While FULL with rsp_ready=0: rsp_data, rsp_id and rsp_valid stay stable; no accept.
- last_grant updates only on accept. A requester that drops req_valid before acceptance loses nothing; pointer is unchanged.
- Arithmetic is pure bitwise at WIDTH bits. There is no carry and no sign handling.

## Timing
- Reset values: rsp_valid=0, rsp_data=0, rsp_id=0, last_grant=N_REQ-1 (requester 0 has first priority), grant_count=0.
- req_ready is combinational from req_valid, rsp_valid, rsp_ready and last_grant. It does not depend on req_op, req_a or req_b.
- Latency is 1 cycle: accept at edge k makes rsp_valid high after edge k, with the result visible.
- Throughput is 1 result per cycle when rsp_ready is held high.
- Reset mid-operation clears any held result immediately (asynchronous). No response is emitted for it.
- Requesters must hold req_op, req_a and req_b stable while req_valid is high and unaccepted.

## Configuration
- LOGIC_ARB_STATS_EN defined:
  - grant_count[i] increments by 1 on each accept from requester i.
  - Counters saturate at 16'hFFFF and clear only on reset.
- LOGIC_ARB_STATS_EN not defined:
  - grant_count is tied to 0 and no counter flops are built.
  - The port list is identical in both builds.

## Structure
- logic_arb_pkg contains:
  - op_t, a 2-bit enum: OP_AND, OP_OR, OP_XOR, OP_NAND.
  - A function giving the ID width for N_REQ.
  - The constant STAT_W=16.
- Sub-module logic_op_unit is purely combinational: inputs op_t op, a, b; output y (WIDTH bits).
  - Instantiated exactly once, fed from the granted requester's mux.
- Round-robin search, response register and stats live in logic_unit_arbiter.

## Test plan
- Reset check: assert reset mid-run with rsp_valid=1 -> rsp_valid, rsp_data, rsp_id and grant_count read 0 during reset, with no clock edge needed.
- Single request: requester 2, op=10, a=16'hF0F0, b=16'h0FF0 -> req_ready=4'b0100 same cycle; next cycle rsp_valid=1, rsp_id=2, rsp_data=16'hFF00.
- Round-robin: all four valid continuously, rsp_ready=1 -> grants in order 0,1,2,3,0,1 on consecutive cycles.
- Backpressure: hold rsp_ready=0 for 5 cycles with requester 1 valid -> req_ready=0 throughout and rsp_data/rsp_id unchanged. Raise rsp_ready -> requester 1 is accepted in that same cycle.
- NAND and all ops: a=16'hFFFF, b=16'h00FF for ops 00/01/10/11 -> 16'h00FF, 16'hFFFF, 16'hFF00, 16'hFF00.
- Stats: with LOGIC_ARB_STATS_EN, requester 3 accepted 7 times -> grant_count[3]=7 and others 0. Without the macro -> all grant_count 0.
